// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and default sizing for the direct-mapped
//               write-through cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Default geometry: 64 one-word lines, 16-bit statistics counters
    localparam int DEFAULT_LINES = 64;
    localparam int DEFAULT_CNT_W = 16;

    // Controller states; IDLE is the reset state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } cache_state_e;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_line_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_array
// Description : Valid/tag/data storage for a direct-mapped cache.
//               Asynchronous read port, single synchronous write port,
//               synchronous clear of all valid bits. Tag and data arrays
//               are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_array
    import cache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int IDX_W = $clog2(DEFAULT_LINES),
    parameter int TAG_W = 30 - $clog2(DEFAULT_LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_data,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    // Valid bits: cleared by reset, set when a line is filled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload: written on fill, never reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    // Asynchronous lookup so a read hit can complete in the request cycle
    always_comb begin
        o_rd_valid = r_valid[i_rd_idx];
        o_rd_tag   = r_tag[i_rd_idx];
        o_rd_data  = r_data[i_rd_idx];
    end

endmodule : cache_line_array
`default_nettype wire

// File: rtl/direct_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : direct_cache_ctrl
// Description : Direct-mapped, one-word-per-line, write-through /
//               write-allocate cache controller between a CPU port and a
//               slow RAM port. Read hits complete combinationally in the
//               request cycle; read misses fetch from RAM and bypass the
//               returned word to the CPU. Saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module direct_cache_ctrl
    import cache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      p_a,
    input  logic [31:0]      p_wdata,
    input  logic             p_strobe,
    input  logic             p_rw,
    output logic [31:0]      p_rdata,
    output logic             p_ready,
    output logic [31:0]      m_a,
    output logic [31:0]      m_dout,
    input  logic [31:0]      m_din,
    output logic             m_strobe,
    output logic             m_rw,
    input  logic             m_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int             c_IDX_W   = $clog2(LINES);
    localparam int             c_TAG_W   = 30 - c_IDX_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    cache_state_e        r_state;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;
    logic                r_m_strobe;
    logic                r_m_rw;
    logic [31:0]         r_m_a;
    logic [31:0]         r_m_dout;

    logic [c_IDX_W-1:0]  w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic                w_line_valid;
    logic [c_TAG_W-1:0]  w_line_tag;
    logic [31:0]         w_line_data;
    logic                w_hit;
    logic                w_busy;
    logic                w_fill;
    logic [31:0]         w_fill_data;
    logic                w_unused_addr;

    // Address decomposition; the byte offset is not part of the lookup
    assign w_idx         = p_a[c_IDX_W+1:2];
    assign w_tag         = p_a[31:c_IDX_W+2];
    assign w_unused_addr = ^p_a[1:0];

    assign w_hit  = w_line_valid && (w_line_tag == w_tag);
    assign w_busy = (r_state == RD_MISS) || (r_state == WR_THRU);

    // A line is filled on RAM completion; reset abandons the transfer
    assign w_fill      = w_busy && m_ready && !clr;
    assign w_fill_data = (r_state == RD_MISS) ? m_din : p_wdata;

    cache_line_array #(
        .LINES (LINES),
        .IDX_W (c_IDX_W),
        .TAG_W (c_TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst        (clr),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_we       (w_fill),
        .i_wr_idx   (w_idx),
        .i_wr_tag   (w_tag),
        .i_wr_data  (w_fill_data)
    );

    // Controller FSM with registered RAM-side outputs and saturating counters
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= IDLE;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_m_strobe <= 1'b0;
            r_m_rw     <= 1'b0;
            r_m_a      <= '0;
            r_m_dout   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (p_strobe) begin
                        if (p_rw) begin
                            r_state    <= WR_THRU;
                            r_m_strobe <= 1'b1;
                            r_m_rw     <= 1'b1;
                            r_m_a      <= {p_a[31:2], 2'b00};
                            r_m_dout   <= p_wdata;
                        end else if (w_hit) begin
                            if (r_hit_cnt != c_CNT_MAX) begin
                                r_hit_cnt <= r_hit_cnt + c_CNT_ONE;
                            end
                        end else begin
                            r_state    <= RD_MISS;
                            r_m_strobe <= 1'b1;
                            r_m_rw     <= 1'b0;
                            r_m_a      <= {p_a[31:2], 2'b00};
                            r_m_dout   <= '0;
                            if (r_miss_cnt != c_CNT_MAX) begin
                                r_miss_cnt <= r_miss_cnt + c_CNT_ONE;
                            end
                        end
                    end
                end
                RD_MISS, WR_THRU: begin
                    if (m_ready) begin
                        r_state    <= IDLE;
                        r_m_strobe <= 1'b0;
                        r_m_rw     <= 1'b0;
                        r_m_a      <= '0;
                        r_m_dout   <= '0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_m_strobe <= 1'b0;
                    r_m_rw     <= 1'b0;
                    r_m_a      <= '0;
                    r_m_dout   <= '0;
                end
            endcase
        end
    end

    // CPU completion: zero-latency read hit, or RAM completion with bypass
    always_comb begin
        p_ready = 1'b0;
        p_rdata = '0;
        if (r_state == IDLE) begin
            if (p_strobe && !p_rw && w_hit) begin
                p_ready = 1'b1;
                p_rdata = w_line_data;
            end
        end else if (w_busy && m_ready) begin
            p_ready = 1'b1;
            if (r_state == RD_MISS) begin
                p_rdata = m_din;
            end
        end
    end

    assign m_strobe = r_m_strobe;
    assign m_rw     = r_m_rw;
    assign m_a      = r_m_a;
    assign m_dout   = r_m_dout;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule : direct_cache_ctrl
`default_nettype wire

// File: tb/tb_direct_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_direct_cache_ctrl
// Description : Directed self-checking bench for direct_cache_ctrl with a
//               small slow-RAM model (fixed two-cycle response).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_direct_cache_ctrl;

    localparam int c_LINES   = 64;
    localparam int c_CNT_W   = 4;
    localparam int c_RAM_LAT = 2;

    logic               clk;
    logic               clr;
    logic [31:0]        p_a;
    logic [31:0]        p_wdata;
    logic               p_strobe;
    logic               p_rw;
    logic [31:0]        p_rdata;
    logic               p_ready;
    logic [31:0]        m_a;
    logic [31:0]        m_dout;
    logic [31:0]        m_din;
    logic               m_strobe;
    logic               m_rw;
    logic               m_ready;
    logic [c_CNT_W-1:0] hit_cnt;
    logic [c_CNT_W-1:0] miss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Results of the most recent CPU transaction
    int          r_lat;
    logic [31:0] r_data;
    logic        r_saw_m;
    logic [31:0] r_snap_a;
    logic        r_snap_rw;
    logic [31:0] r_snap_dout;

    direct_cache_ctrl #(
        .LINES (c_LINES),
        .CNT_W (c_CNT_W)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .p_a      (p_a),
        .p_wdata  (p_wdata),
        .p_strobe (p_strobe),
        .p_rw     (p_rw),
        .p_rdata  (p_rdata),
        .p_ready  (p_ready),
        .m_a      (m_a),
        .m_dout   (m_dout),
        .m_din    (m_din),
        .m_strobe (m_strobe),
        .m_rw     (m_rw),
        .m_ready  (m_ready),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slow RAM model: unwritten words read as {16'hA5A5, addr[15:0]}
    logic [31:0]   ram     [1024];
    logic [1023:0] ram_vld;
    logic          ram_init;
    int            ram_cnt;

    always @(posedge clk) begin
        if (ram_init) begin
            ram_vld <= '0;
        end
        if (clr) begin
            ram_cnt <= 0;
            m_ready <= 1'b0;
            m_din   <= '0;
        end else begin
            m_ready <= 1'b0;
            if (m_strobe && !m_ready) begin
                if (ram_cnt == c_RAM_LAT - 1) begin
                    ram_cnt <= 0;
                    m_ready <= 1'b1;
                    if (m_rw) begin
                        ram[m_a[11:2]]     <= m_dout;
                        ram_vld[m_a[11:2]] <= 1'b1;
                    end else begin
                        m_din <= ram_vld[m_a[11:2]] ? ram[m_a[11:2]]
                                                    : {16'hA5A5, m_a[15:0]};
                    end
                end else begin
                    ram_cnt <= ram_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One CPU transaction; records latency (edges until p_ready) and RAM request
    task automatic cpu_xfer(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
        logic done;
        @(posedge clk);
        #1;
        p_strobe = 1'b1;
        p_rw     = rw;
        p_a      = addr;
        p_wdata  = wdata;
        done     = 1'b0;
        r_lat    = 0;
        r_saw_m  = 1'b0;
        r_data   = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (m_strobe && !r_saw_m) begin
                r_saw_m     = 1'b1;
                r_snap_a    = m_a;
                r_snap_rw   = m_rw;
                r_snap_dout = m_dout;
            end
            if (p_ready) begin
                done   = 1'b1;
                r_data = p_rdata;
            end else begin
                @(posedge clk);
                r_lat++;
            end
        end
        if (!done) check("xfer_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        p_strobe = 1'b0;
        p_rw     = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        clr      = 1'b1;
        ram_init = 1'b1;
        p_a      = '0;
        p_wdata  = '0;
        p_strobe = 1'b0;
        p_rw     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ram_init = 1'b0;
        clr      = 1'b0;

        // Post-reset output state
        check("rst_p_ready",  32'(p_ready),  32'd0);
        check("rst_p_rdata",  p_rdata,       32'd0);
        check("rst_m_strobe", 32'(m_strobe), 32'd0);
        check("rst_m_rw",     32'(m_rw),     32'd0);
        check("rst_m_a",      m_a,           32'd0);
        check("rst_m_dout",   m_dout,        32'd0);
        check("rst_hit_cnt",  32'(hit_cnt),  32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);

        // Cold read of 0x40 misses and is filled from RAM
        cpu_xfer(1'b0, 32'h0000_0040, 32'h0);
        check("miss40_m_strobe", 32'(r_saw_m),   32'd1);
        check("miss40_m_a",      r_snap_a,       32'h0000_0040);
        check("miss40_m_rw",     32'(r_snap_rw), 32'd0);
        check("miss40_data",     r_data,         32'hA5A5_0040);
        check("miss40_lat",      32'(r_lat),     32'd3);
        check("miss40_miss_cnt", 32'(miss_cnt),  32'd1);
        check("miss40_hit_cnt",  32'(hit_cnt),   32'd0);

        // Repeat read hits in the request cycle without touching RAM
        cpu_xfer(1'b0, 32'h0000_0040, 32'h0);
        check("hit40_lat",      32'(r_lat),    32'd0);
        check("hit40_m_strobe", 32'(r_saw_m),  32'd0);
        check("hit40_data",     r_data,        32'hA5A5_0040);
        check("hit40_hit_cnt",  32'(hit_cnt),  32'd1);

        // Write-through with allocate, then read hit on the written word
        cpu_xfer(1'b1, 32'h0000_0000, 32'h0000_0015);
        check("wr0_m_strobe", 32'(r_saw_m),   32'd1);
        check("wr0_m_rw",     32'(r_snap_rw), 32'd1);
        check("wr0_m_a",      r_snap_a,       32'h0000_0000);
        check("wr0_m_dout",   r_snap_dout,    32'h0000_0015);
        check("wr0_lat",      32'(r_lat),     32'd3);
        check("wr0_miss_cnt", 32'(miss_cnt),  32'd1);
        check("wr0_hit_cnt",  32'(hit_cnt),   32'd1);
        cpu_xfer(1'b0, 32'h0000_0000, 32'h0);
        check("rd0_lat",     32'(r_lat),   32'd0);
        check("rd0_data",    r_data,       32'h0000_0015);
        check("rd0_hit_cnt", 32'(hit_cnt), 32'd2);

        // Conflict misses on the same index after a fresh reset
        do_reset();
        check("clr_hit_cnt",  32'(hit_cnt),  32'd0);
        check("clr_miss_cnt", 32'(miss_cnt), 32'd0);
        cpu_xfer(1'b0, 32'h0000_0000, 32'h0);
        check("conf_a_lat",  32'(r_lat), 32'd3);
        check("conf_a_data", r_data,     32'h0000_0015);
        cpu_xfer(1'b0, 32'h0000_0100, 32'h0);
        check("conf_b_lat",  32'(r_lat), 32'd3);
        check("conf_b_data", r_data,     32'hA5A5_0100);
        cpu_xfer(1'b0, 32'h0000_0000, 32'h0);
        check("conf_c_lat",  32'(r_lat), 32'd3);
        check("conf_c_data", r_data,     32'h0000_0015);
        check("conf_miss_cnt", 32'(miss_cnt), 32'd3);
        check("conf_hit_cnt",  32'(hit_cnt),  32'd0);

        // Reset in the middle of a read miss abandons it
        @(posedge clk);
        #1;
        p_strobe = 1'b1;
        p_rw     = 1'b0;
        p_a      = 32'h0000_0080;
        @(posedge clk);
        #1;
        check("abort_m_strobe_on", 32'(m_strobe), 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("abort_m_strobe_off", 32'(m_strobe), 32'd0);
        check("abort_p_ready",      32'(p_ready),  32'd0);
        check("abort_m_a",          m_a,           32'd0);
        clr      = 1'b0;
        p_strobe = 1'b0;
        cpu_xfer(1'b0, 32'h0000_0080, 32'h0);
        check("abort_reread_lat",  32'(r_lat),    32'd3);
        check("abort_reread_data", r_data,        32'hA5A5_0080);
        check("abort_miss_cnt",    32'(miss_cnt), 32'd1);

        // Hit counter saturates at all-ones
        for (int i = 0; i < 20; i++) begin
            cpu_xfer(1'b0, 32'h0000_0080, 32'h0);
        end
        check("sat_hit_cnt",  32'(hit_cnt),  32'h0000_000F);
        check("sat_miss_cnt", 32'(miss_cnt), 32'd1);
        check("sat_last_data", r_data,       32'hA5A5_0080);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_direct_cache_ctrl
`default_nettype wire

// File: doc/direct_cache_ctrl.md
DIRECT_CACHE_CTRL -- requirements
Module: direct_cache_ctrl

Interface
REQ-001 The block SHALL have parameter LINES, default 64, number of one-word cache lines (power of 2, 2..1024).
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the hit/miss counters.
REQ-003 The block SHALL have ports: clk  in  1  single clock, all state changes on rising edge.
REQ-004 clr  in  1  reset, synchronous and active-high.
REQ-005 p_a  in  32  CPU byte address, word-aligned; bits [1:0] ignored.
REQ-006 p_wdata  in  32  CPU write data.
REQ-007 p_strobe  in  1  CPU request valid; held with p_a/p_rw/p_wdata stable until p_ready.
REQ-008 p_rw  in  1  1 = write, 0 = read.
REQ-009 p_rdata  out  32  read data to CPU, valid while p_ready & !p_rw.
REQ-010 p_ready  out  1  one-cycle request-complete pulse.
REQ-011 m_a  out  32  address to slow_ram.
REQ-012 m_dout  out  32  write data to slow_ram (drives its m_din).
REQ-013 m_din  in  32  read data from slow_ram (driven by its m_dout).
REQ-014 m_strobe  out  1  slow_ram request, held until m_ready.
REQ-015 m_rw  out  1  slow_ram direction, 1 = write.
REQ-016 m_ready  in  1  slow_ram completion.
REQ-017 hit_cnt, miss_cnt  out  CNT_W  read hit / read miss counters.

Function
REQ-018 Address split SHALL be index = p_a[log2(LINES)+1:2], tag = p_a[31:log2(LINES)+2]; hit = valid[index] & tag match.
REQ-019 FSM states SHALL be IDLE, RD_MISS, WR_THRU; IDLE is the reset state.
REQ-020 IDLE, p_strobe & !p_rw & hit: p_ready=1 and p_rdata=line data combinationally in the same cycle; stay IDLE; hit_cnt increments.
REQ-021 IDLE, p_strobe & !p_rw & miss: go to RD_MISS next cycle; miss_cnt increments once; p_ready=0.
REQ-022 IDLE, p_strobe & p_rw: go to WR_THRU next cycle; hit state irrelevant; no counter change.
REQ-023 RD_MISS: m_strobe=1, m_rw=0, m_a={p_a[31:2],2'b00}; in the m_ready cycle p_rdata=m_din (bypass), p_ready=1, and at that edge the line is written (data=m_din, tag, valid=1); next state IDLE.
REQ-024 WR_THRU: m_strobe=1, m_rw=1, m_a as above, m_dout=p_wdata; in the m_ready cycle p_ready=1 and at that edge the line is written (data=p_wdata, tag, valid=1, write-allocate); next state IDLE.
REQ-025 Outside RD_MISS/WR_THRU, m_strobe SHALL be 0; m_a/m_dout/m_rw are don't-care but SHALL not be X after reset.
REQ-026 Miss latency SHALL be 1 + slow_ram latency cycles; read-hit latency SHALL be 0 cycles.
REQ-027 p_strobe still high in IDLE after p_ready SHALL be treated as a new request.
REQ-028 p_strobe=0 in IDLE SHALL produce no activity; m_ready outside RD_MISS/WR_THRU SHALL be ignored.
REQ-029 Counters SHALL saturate at all-ones, not wrap.

Reset
REQ-030 clr=1 at a rising edge SHALL set state=IDLE, clear all valid bits, clear hit_cnt/miss_cnt; outputs p_ready=0, m_strobe=0, m_rw=0, m_a=0, m_dout=0, p_rdata=0 the following cycle.
REQ-031 clr during RD_MISS/WR_THRU SHALL abandon the transfer without a cache update; slow_ram SHALL share the same reset.
REQ-032 Tag/data arrays need no reset.

Structure
REQ-033 Package cache_pkg SHALL hold the state enum and default LINES/CNT_W constants.
REQ-034 Sub-module cache_line_array SHALL hold the valid/tag/data storage (async read, single sync write port, sync valid clear).

Verification
REQ-035 Reset, read 0x40 -> miss: m_strobe rd to 0x40, p_ready with slow_ram data, miss_cnt=1.
REQ-036 Repeat read 0x40 -> p_ready same cycle as p_strobe, no m_strobe, hit_cnt=1.
REQ-037 Write 0x15 to 0x0 -> m_strobe/m_rw=1, m_dout=0x15; then read 0x0 -> hit returns 0x15.
REQ-038 Read 0x0 then 0x100 (same index, LINES=64) then 0x0 -> miss, miss, miss; miss_cnt=3.
REQ-039 clr asserted mid-RD_MISS -> m_strobe=0 next cycle, no p_ready, following read of same address misses.
REQ-040 Force hit_cnt to all-ones via CNT_W=4 and 20 hits -> hit_cnt stays 0xF.
